// File: rtl/pe_xbar_pkg.sv
// rtl/pe_xbar_pkg.sv - shared widths, defaults and null-route select for the PE crossbar
package pe_xbar_pkg;

    localparam int DEF_NUM_IN    = 7;
    localparam int DEF_NUM_OUT   = 6;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_CTX_DEPTH = 4;

    // All-ones select; callers take the low SEL_W bits.
    localparam logic [31:0] SEL_NULL = '1;

    // Index width for n entries, never narrower than one bit.
    function automatic int xbar_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pe_xbar_mux.sv
// rtl/pe_xbar_mux.sv - one NUM_IN:1 data/valid mux; out-of-range selects give a null route
module pe_xbar_mux
    import pe_xbar_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = xbar_width(DEF_NUM_IN + 1)
) (
    input  logic [NUM_IN*DATA_W-1:0] din,
    input  logic [NUM_IN-1:0]        din_vld,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_vld
);

    always_comb begin
        dout     = '0;
        dout_vld = 1'b0;
        for (int j = 0; j < NUM_IN; j++) begin
            if (sel == SEL_W'(j)) begin
                dout     = din[j*DATA_W +: DATA_W];
                dout_vld = din_vld[j];
            end
        end
    end

endmodule

// File: rtl/pe_xbar_ctx.sv
// rtl/pe_xbar_ctx.sv - multi-context PE crossbar; PE_XBAR_OUT_REG_EN registers dout/dout_vld
module pe_xbar_ctx
    import pe_xbar_pkg::*;
#(
    parameter  int NUM_IN    = DEF_NUM_IN,
    parameter  int NUM_OUT   = DEF_NUM_OUT,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int CTX_DEPTH = DEF_CTX_DEPTH,
    localparam int SEL_W     = xbar_width(NUM_IN + 1),
    localparam int CTX_AW    = xbar_width(CTX_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [CTX_AW-1:0]         cfg_addr,
    input  logic [NUM_OUT*SEL_W-1:0]  cfg_data,
    input  logic [CTX_AW-1:0]         ctx_last,
    input  logic                      step,
    input  logic                      ctx_clr,
    input  logic [NUM_IN*DATA_W-1:0]  din,
    input  logic [NUM_IN-1:0]         din_vld,
    output logic [NUM_OUT*DATA_W-1:0] dout,
    output logic [NUM_OUT-1:0]        dout_vld,
    output logic [CTX_AW-1:0]         ctx_idx
);

    localparam int               CFG_W    = NUM_OUT * SEL_W;
    localparam logic [SEL_W-1:0] NULL_SEL = SEL_NULL[SEL_W-1:0];

    logic [CFG_W-1:0]          cfg_mem [CTX_DEPTH];
    logic [CFG_W-1:0]          active_sel;
    logic [NUM_OUT*DATA_W-1:0] route_data;
    logic [NUM_OUT-1:0]        route_vld;

    // Reads see the pre-write contents in the cycle of a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CTX_DEPTH; i++) begin
                cfg_mem[i] <= {NUM_OUT{NULL_SEL}};
            end
        end else if (cfg_we) begin
            cfg_mem[cfg_addr] <= cfg_data;
        end
    end

    assign active_sel = cfg_mem[ctx_idx];

    // >= rather than == so a ctx_last lowered below ctx_idx still wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx_idx <= '0;
        end else if (ctx_clr) begin
            ctx_idx <= '0;
        end else if (step) begin
            if (ctx_idx >= ctx_last) begin
                ctx_idx <= '0;
            end else begin
                ctx_idx <= ctx_idx + CTX_AW'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_mux
        pe_xbar_mux #(
            .NUM_IN (NUM_IN),
            .DATA_W (DATA_W),
            .SEL_W  (SEL_W)
        ) u_mux (
            .din      (din),
            .din_vld  (din_vld),
            .sel      (active_sel[k*SEL_W +: SEL_W]),
            .dout     (route_data[k*DATA_W +: DATA_W]),
            .dout_vld (route_vld[k])
        );
    end

`ifdef PE_XBAR_OUT_REG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            dout_vld <= '0;
        end else begin
            dout     <= route_data;
            dout_vld <= route_vld;
        end
    end
`else
    // Reset null-routes every context, so these read as zero during reset.
    assign dout     = route_data;
    assign dout_vld = route_vld;
`endif

endmodule

// File: tb/tb_pe_xbar_ctx.sv
// tb/tb_pe_xbar_ctx.sv - randomized self-checking bench for pe_xbar_ctx against a context/route model
module tb_pe_xbar_ctx;

    localparam int NI = 7;
    localparam int NO = 6;
    localparam int DW = 32;
    localparam int CD = 4;
    localparam int SW = 3;
    localparam int AW = 2;

`ifdef PE_XBAR_OUT_REG_EN
    localparam bit OUT_REG = 1'b1;
`else
    localparam bit OUT_REG = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [NO*SW-1:0]  cfg_data;
    logic [AW-1:0]     ctx_last;
    logic              step;
    logic              ctx_clr;
    logic [NI*DW-1:0]  din;
    logic [NI-1:0]     din_vld;
    logic [NO*DW-1:0]  dout;
    logic [NO-1:0]     dout_vld;
    logic [AW-1:0]     ctx_idx;

    int checks = 0;
    int errors = 0;

    int               cfg_m [CD][NO];
    int               ctx_m;
    logic [NO*DW-1:0] prev_d;
    logic [NO-1:0]    prev_v;

    pe_xbar_ctx #(
        .NUM_IN    (NI),
        .NUM_OUT   (NO),
        .DATA_W    (DW),
        .CTX_DEPTH (CD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .ctx_last (ctx_last),
        .step     (step),
        .ctx_clr  (ctx_clr),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout),
        .dout_vld (dout_vld),
        .ctx_idx  (ctx_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NO*SW-1:0] sels(input int s0, s1, s2, s3, s4, s5);
        logic [NO*SW-1:0] v;
        v = {SW'(s5), SW'(s4), SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
        return v;
    endfunction

    // Output k carries source cfg[k] when that index names a real source, else nothing.
    task automatic route(input int c, input logic [NI*DW-1:0] d, input logic [NI-1:0] v,
                         output logic [NO*DW-1:0] od, output logic [NO-1:0] ov);
        od = '0;
        ov = '0;
        for (int k = 0; k < NO; k++) begin
            int s;
            s = cfg_m[c][k];
            if (s < NI) begin
                od[k*DW +: DW] = d[s*DW +: DW];
                ov[k]          = v[s];
            end
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CD; c++)
            for (int k = 0; k < NO; k++)
                cfg_m[c][k] = 7;
        ctx_m  = 0;
        prev_d = '0;
        prev_v = '0;
    endtask

    task automatic set_din_seq(input int base);
        for (int j = 0; j < NI; j++) din[j*DW +: DW] = DW'(base + j);
        din_vld = '1;
    endtask

    task automatic rand_din();
        for (int j = 0; j < NI; j++) din[j*DW +: DW] = $urandom;
        din_vld = NI'($urandom);
    endtask

    // Check mid-cycle, then apply the clock edge to the model and drop one-cycle pulses.
    task automatic cycle();
        logic [NO*DW-1:0] ed;
        logic [NO-1:0]    ev;
        @(negedge clk);
        route(ctx_m, din, din_vld, ed, ev);
        chk("ctx_idx", 256'(ctx_idx), 256'(ctx_m));
        chk("dout", 256'(dout), 256'(OUT_REG ? prev_d : ed));
        chk("dout_vld", 256'(dout_vld), 256'(OUT_REG ? prev_v : ev));
        @(posedge clk);
        #1;
        if (cfg_we)
            for (int k = 0; k < NO; k++) cfg_m[cfg_addr][k] = int'(cfg_data[k*SW +: SW]);
        if (ctx_clr)
            ctx_m = 0;
        else if (step)
            ctx_m = (ctx_m >= int'(ctx_last)) ? 0 : ctx_m + 1;
        prev_d  = ed;
        prev_v  = ev;
        step    = 1'b0;
        ctx_clr = 1'b0;
        cfg_we  = 1'b0;
    endtask

    initial begin
        logic [NO*DW-1:0] exp_d;

        rst      = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        ctx_last = '0;
        step     = 1'b0;
        ctx_clr  = 1'b0;
        set_din_seq(32'h1000);
        model_reset();

        @(negedge clk);
        chk("rst_ctx", 256'(ctx_idx), 256'(0));
        chk("rst_dout", 256'(dout), 256'(0));
        chk("rst_vld", 256'(dout_vld), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        cycle();

        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = sels(0, 1, 2, 3, 4, 5);
        set_din_seq(32'hA0);
        cycle();
        cycle();
        cycle();
        for (int k = 0; k < NO; k++) exp_d[k*DW +: DW] = DW'(32'hA0 + k);
        chk("ctx0_dout", 256'(dout), 256'(exp_d));
        chk("ctx0_vld", 256'(dout_vld), 256'(6'h3F));

        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = sels(5, 4, 3, 2, 1, 0);
        cycle();
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = sels(6, 6, 0, 1, 7, 3);
        ctx_last = 2'd2;
        cycle();
        for (int p = 0; p < 4; p++) begin
            rand_din();
            step = 1'b1;
            cycle();
            cycle();
        end
        chk("step4_ctx", 256'(ctx_idx), 256'(1));

        step = 1'b1; ctx_clr = 1'b1;
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = sels(2, 2, 2, 2, 2, 2);
        cycle();
        chk("clr_ctx", 256'(ctx_idx), 256'(0));
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = sels(0, 1, 7, 3, 4, 4);
        set_din_seq(32'h500);
        din_vld[4] = 1'b0;
        cycle();
        cycle();
        cycle();
        chk("null_d2", 256'(dout[2*DW +: DW]), 256'(0));
        chk("null_v2", 256'(dout_vld[2]), 256'(0));
        chk("inv_v5", 256'(dout_vld[5]), 256'(0));
        chk("inv_v4", 256'(dout_vld[4]), 256'(0));
        chk("share_d5", 256'(dout[5*DW +: DW]), 256'(32'h504));

        for (int i = 0; i < 300; i++) begin
            rand_din();
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_addr = AW'($urandom);
            cfg_data = (NO*SW)'($urandom);
            if ($urandom_range(0, 7) == 0) ctx_last = AW'($urandom);
            step     = $urandom_range(0, 1) == 1;
            ctx_clr  = ($urandom_range(0, 15) == 0);
            cycle();
        end

        ctx_clr = 1'b1; ctx_last = 2'd3;
        cycle();
        step = 1'b1;
        cycle();
        step = 1'b1;
        cycle();
        chk("pre_rst_ctx", 256'(ctx_idx), 256'(2));
        #3;
        rst = 1'b1;
        #1;
        chk("async_ctx", 256'(ctx_idx), 256'(0));
        chk("async_dout", 256'(dout), 256'(0));
        chk("async_vld", 256'(dout_vld), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            set_din_seq(32'h700 + i);
            step = $urandom_range(0, 1) == 1;
            cycle();
        end
        chk("post_rst_vld", 256'(dout_vld), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
